imm_gen_pipe: RTL

- Pipelined, parametrised immediate generator for the LEGv8 datapath; successor to the combinational sign extender.
- Decodes the immediate field of the D, CB, B, I and IW instruction formats and extends it to N bits.
- Holds the result in a registered output stage with a valid/ready handshake and a 2-entry skid buffer.
- Sits between the IF/ID register and the ID/EX register. A decode stall cannot drop an instruction, and the block never adds bubbles.

---
 rtl/imm_pkg.sv | 39 +++
 rtl/imm_decode.sv | 60 ++++++
 rtl/imm_gen_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared format codes, opcode patterns and field positions for the LEGv8 immediate generator
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_D    = 3'd1,
      FMT_CB   = 3'd2,
      FMT_B    = 3'd3,
      FMT_I    = 3'd4,
      FMT_IW   = 3'd5
   } imm_fmt_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   // Opcode patterns matched against instr[31:21]; '?' bits are don't-care.
   localparam logic [10:0] OPC_D  = 11'b111_1100_00?0;
   localparam logic [10:0] OPC_CB = 11'b101_1010_????;
   localparam logic [10:0] OPC_B  = 11'b?00_101?_????;
   localparam logic [10:0] OPC_I  = 11'b1?0_1000_100?;
   localparam logic [10:0] OPC_IW = 11'b110_1001_01??;

   localparam int D_MSB  = 20;
   localparam int D_LSB  = 12;
   localparam int CB_MSB = 23;
   localparam int CB_LSB = 5;
   localparam int B_MSB  = 25;
   localparam int B_LSB  = 0;
   localparam int I_MSB  = 21;
   localparam int I_LSB  = 10;
   localparam int IW_MSB = 20;
   localparam int IW_LSB = 5;
   localparam int HW_MSB = 22;
   localparam int HW_LSB = 21;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate decode for D/CB/B/I/IW formats (BRANCH_SHIFT_EN: CB/B as byte offset)
module imm_decode
   import imm_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [31:0]  instr,
   output logic [N-1:0] imm,
   output imm_fmt_t     fmt,
   output logic         illegal
);

   // Bits of the 64-bit extension that do not fit in N; empty when N == 64.
   localparam logic [63:0] HI_MASK = ~((64'd1 << N) - 64'd1);

   logic [63:0] imm64;

   always_comb begin
      imm64   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      casez (instr[31:21])
         OPC_D: begin
            fmt   = FMT_D;
            imm64 = 64'($signed(instr[D_MSB:D_LSB]));
         end
         OPC_CB: begin
            fmt   = FMT_CB;
`ifdef BRANCH_SHIFT_EN
            imm64 = 64'($signed(instr[CB_MSB:CB_LSB])) << 2;
`else
            imm64 = 64'($signed(instr[CB_MSB:CB_LSB]));
`endif
         end
         OPC_B: begin
            fmt   = FMT_B;
`ifdef BRANCH_SHIFT_EN
            imm64 = 64'($signed(instr[B_MSB:B_LSB])) << 2;
`else
            imm64 = 64'($signed(instr[B_MSB:B_LSB]));
`endif
         end
         OPC_I: begin
            fmt   = FMT_I;
            imm64 = 64'(instr[I_MSB:I_LSB]);
         end
         OPC_IW: begin
            fmt     = FMT_IW;
            imm64   = 64'(instr[IW_MSB:IW_LSB]) << {instr[HW_MSB:HW_LSB], 4'b0000};
            illegal = |(imm64 & HI_MASK);
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = imm64[N-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with registered output and 2-entry skid buffer (BRANCH_SHIFT_EN optional)
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int N     = 64,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [N-1:0] dec_imm;
   imm_fmt_t     dec_fmt;
   logic         dec_illegal;

   imm_decode #(.N(N)) u_decode (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   skid_state_t      state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [N-1:0]     out_imm_q,  skid_imm_q;
   imm_fmt_t         out_fmt_q,  skid_fmt_q;
   logic             out_ill_q,  skid_ill_q;
   logic [TAG_W-1:0] out_tag_q,  skid_tag_q;

   logic in_xfer, out_xfer;
   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_imm_q   <= '0;
         out_fmt_q   <= FMT_NONE;
         out_ill_q   <= 1'b0;
         out_tag_q   <= '0;
         skid_imm_q  <= '0;
         skid_fmt_q  <= FMT_NONE;
         skid_ill_q  <= 1'b0;
         skid_tag_q  <= '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  out_imm_q   <= dec_imm;
                  out_fmt_q   <= dec_fmt;
                  out_ill_q   <= dec_illegal;
                  out_tag_q   <= in_tag;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  out_imm_q <= dec_imm;
                  out_fmt_q <= dec_fmt;
                  out_ill_q <= dec_illegal;
                  out_tag_q <= in_tag;
               end else if (in_xfer) begin
                  // Consumer stalled: park the new word behind the held output.
                  skid_imm_q <= dec_imm;
                  skid_fmt_q <= dec_fmt;
                  skid_ill_q <= dec_illegal;
                  skid_tag_q <= in_tag;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_FULL;
               end else if (out_xfer) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  out_imm_q  <= skid_imm_q;
                  out_fmt_q  <= skid_fmt_q;
                  out_ill_q  <= skid_ill_q;
                  out_tag_q  <= skid_tag_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_ONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_EMPTY;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_imm_q;
   assign out_fmt     = out_fmt_q;
   assign out_illegal = out_ill_q;
   assign out_tag     = out_tag_q;

endmodule
